// File: rtl/alert_pkg.sv
// Shared types and the per-alert beep pattern table for the buzzer alert sequencer.
package alert_pkg;

    typedef enum logic [1:0] {
        CODE_OK     = 2'd0,
        CODE_ERROR  = 2'd1,
        CODE_COIN   = 2'd2,
        CODE_CANCEL = 2'd3
    } alert_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int MS_W = 9;

    // Indexed by alert code: beep count, tone-on time and inter-beep gap in ms.
    localparam logic [1:0]      BEEPS  [4] = '{2'd1, 2'd3, 2'd1, 2'd2};
    localparam logic [MS_W-1:0] ON_MS  [4] = '{9'd200, 9'd100, 9'd50, 9'd300};
    localparam logic [MS_W-1:0] OFF_MS [4] = '{9'd0, 9'd100, 9'd0, 9'd150};

endpackage

// File: rtl/alert_sequencer_ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every TICK_DIV cycles, restartable by clr.
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/alert_sequencer.sv
// Plays a fixed on/off beep pattern per alert code on beep_en; pulses done on normal completion.
module alert_sequencer
    import alert_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] code,
    input  logic       abort,
    output logic       beep_en,
    output logic       busy,
    output logic       done
);

    state_t            state_reg, state_next;
    alert_code_t       code_reg, code_next;
    logic [MS_W-1:0]   ms_reg, ms_next;
    logic [1:0]        beeps_left_reg, beeps_left_next;
    logic              beep_reg, beep_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              clr;
    logic              tick;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            code_reg       <= CODE_OK;
            ms_reg         <= '0;
            beeps_left_reg <= '0;
            beep_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            code_reg       <= code_next;
            ms_reg         <= ms_next;
            beeps_left_reg <= beeps_left_next;
            beep_reg       <= beep_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    // Every interval change restarts both counters so each interval is exactly N ms long.
    always_comb begin
        state_next      = state_reg;
        code_next       = code_reg;
        ms_next         = ms_reg;
        beeps_left_next = beeps_left_reg;
        beep_next       = beep_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        clr             = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next      = ST_ON;
                    code_next       = alert_code_t'(code);
                    ms_next         = '0;
                    clr             = 1'b1;
                    beeps_left_next = BEEPS[code] - 2'd1;
                    beep_next       = 1'b1;
                    busy_next       = 1'b1;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    ms_next    = '0;
                    clr        = 1'b1;
                    beep_next  = 1'b0;
                    busy_next  = 1'b0;
                end else if (tick) begin
                    if (ms_reg == ON_MS[code_reg] - 9'd1) begin
                        ms_next   = '0;
                        clr       = 1'b1;
                        beep_next = 1'b0;
                        if (beeps_left_reg != 2'd0) begin
                            state_next = ST_OFF;
                        end else begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        ms_next = ms_reg + 9'd1;
                    end
                end
            end
            ST_OFF: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    ms_next    = '0;
                    clr        = 1'b1;
                    beep_next  = 1'b0;
                    busy_next  = 1'b0;
                end else if (tick) begin
                    if (ms_reg == OFF_MS[code_reg] - 9'd1) begin
                        state_next      = ST_ON;
                        beeps_left_next = beeps_left_reg - 2'd1;
                        ms_next         = '0;
                        clr             = 1'b1;
                        beep_next       = 1'b1;
                    end else begin
                        ms_next = ms_reg + 9'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                beep_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign beep_en = beep_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
